// File: rtl/counter4_readout_if.sv
// Pad-level bundle between the 4-bit routed counter/readout pins and counter4_readout.
// Carries thresh_Pad only when COUNTER4_READOUT_THRESH_CMP_EN is defined.
interface counter4_readout_if;
  logic count0_Pad;
  logic count1_Pad;
  logic count2_Pad;
  logic count3_Pad;
  logic cap_Pad;
  logic ser_Pad;
  logic ser_valid_Pad;
  logic busy_Pad;
  logic wrap_Pad;
  logic drop_Pad;
`ifdef COUNTER4_READOUT_THRESH_CMP_EN
  logic thresh_Pad;
`endif

  modport slave (
    input  count0_Pad, count1_Pad, count2_Pad, count3_Pad, cap_Pad,
    output ser_Pad, ser_valid_Pad, busy_Pad, wrap_Pad, drop_Pad
`ifdef COUNTER4_READOUT_THRESH_CMP_EN
    , output thresh_Pad
`endif
  );

  modport master (
    output count0_Pad, count1_Pad, count2_Pad, count3_Pad, cap_Pad,
    input  ser_Pad, ser_valid_Pad, busy_Pad, wrap_Pad, drop_Pad
`ifdef COUNTER4_READOUT_THRESH_CMP_EN
    , input thresh_Pad
`endif
  );
endinterface

// File: rtl/counter4_readout.sv
// Samples the 4-bit counter pads, flags 15->0 wraps and serialises captured words with a one-deep pending slot.
// Optional threshold pulse output enabled by COUNTER4_READOUT_THRESH_CMP_EN.
module counter4_readout #(
  parameter int          CNT_W     = 4,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned THRESH    = 15
) (
  input  logic            GCLK_Pad,
  input  logic            rst_Pad,
  counter4_readout_if.slave bus
);

  if (CNT_W != 4 || THRESH >= (1 << CNT_W)) begin : g_bad_cfg
    $error("counter4_readout: CNT_W must be 4 and THRESH must fit in it");
  end

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] sh_q, sh_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic       ser_q, ser_d;
  logic       vld_q, vld_d;
  logic       wrap_q, wrap_d;
  logic       drop_q, drop_d;
  logic [3:0] cur;
  logic       cap;

  assign cur = {bus.count3_Pad, bus.count2_Pad, bus.count1_Pad, bus.count0_Pad};
  assign cap = bus.cap_Pad;

  // Bit i of the transmit order for word w.
  function automatic logic pick(input logic [3:0] w, input logic [1:0] i);
    return MSB_FIRST ? w[2'd3 - i] : w[i];
  endfunction

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ser_d      = 1'b0;
    vld_d      = 1'b0;
    drop_d     = 1'b0;
    prev_d     = cur;
    wrap_d     = (prev_q == 4'hF) && (cur == 4'h0);
    case (state_q)
      IDLE: begin
        if (cap) begin
          state_d = SHIFT;
          sh_d    = cur;
          idx_d   = 2'd0;
          vld_d   = 1'b1;
          ser_d   = pick(cur, 2'd0);
        end
      end
      SHIFT: begin
        vld_d = 1'b1;
        if (idx_q == 2'd3) begin
          // Word boundary: pending word goes first, a same-edge request refills pending.
          idx_d = 2'd0;
          if (pend_vld_q) begin
            sh_d       = pend_q;
            ser_d      = pick(pend_q, 2'd0);
            pend_vld_d = cap;
            pend_d     = cap ? cur : pend_q;
          end else if (cap) begin
            sh_d  = cur;
            ser_d = pick(cur, 2'd0);
          end else begin
            state_d = IDLE;
            vld_d   = 1'b0;
          end
        end else begin
          idx_d = idx_q + 2'd1;
          ser_d = pick(sh_q, idx_q + 2'd1);
          if (cap) begin
            if (!pend_vld_q) begin
              pend_vld_d = 1'b1;
              pend_d     = cur;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge GCLK_Pad or negedge rst_Pad) begin
    if (!rst_Pad) begin
      state_q    <= IDLE;
      prev_q     <= 4'h0;
      sh_q       <= 4'h0;
      idx_q      <= 2'd0;
      pend_q     <= 4'h0;
      pend_vld_q <= 1'b0;
      ser_q      <= 1'b0;
      vld_q      <= 1'b0;
      wrap_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      sh_q       <= sh_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ser_q      <= ser_d;
      vld_q      <= vld_d;
      wrap_q     <= wrap_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.ser_Pad       = ser_q;
  assign bus.ser_valid_Pad = vld_q;
  // Pending is only ever occupied while shifting, so busy tracks valid.
  assign bus.busy_Pad      = vld_q;
  assign bus.wrap_Pad      = wrap_q;
  assign bus.drop_Pad      = drop_q;

`ifdef COUNTER4_READOUT_THRESH_CMP_EN
  logic thresh_q, thresh_d;
  localparam logic [3:0] THR = THRESH[3:0];

  always_comb begin
    thresh_d = (cur == THR) && (prev_q != THR);
  end

  always_ff @(posedge GCLK_Pad or negedge rst_Pad) begin
    if (!rst_Pad) thresh_q <= 1'b0;
    else          thresh_q <= thresh_d;
  end

  assign bus.thresh_Pad = thresh_q;
`endif

endmodule

// File: tb/tb_counter4_readout.sv
// Directed + random bench for counter4_readout against a word-queue reference model.
module tb_counter4_readout;
  localparam bit       MSB_FIRST = 1'b0;
  localparam int       THR       = 9;

  logic GCLK_Pad = 1'b0;
  logic rst_Pad  = 1'b0;
  always #5 GCLK_Pad = ~GCLK_Pad;

  counter4_readout_if bus ();

  counter4_readout #(.CNT_W(4), .MSB_FIRST(MSB_FIRST), .THRESH(THR)) dut (
    .GCLK_Pad (GCLK_Pad),
    .rst_Pad  (rst_Pad),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: queue of words in flight (front = shifting, second = pending).
  logic [3:0] q[$];
  int         pos;
  logic [3:0] mprev;
  logic       e_wrap, e_drop, e_thr;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pos    = 0;
    mprev  = 4'h0;
    e_wrap = 1'b0;
    e_drop = 1'b0;
    e_thr  = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    logic ev, es;
    ev = (q.size() > 0);
    es = 1'b0;
    if (ev) es = MSB_FIRST ? q[0][3 - pos] : q[0][pos];
    chk({tag, ".ser"},       bus.ser_Pad,       es);
    chk({tag, ".ser_valid"}, bus.ser_valid_Pad, ev);
    chk({tag, ".busy"},      bus.busy_Pad,      ev);
    chk({tag, ".wrap"},      bus.wrap_Pad,      e_wrap);
    chk({tag, ".drop"},      bus.drop_Pad,      e_drop);
`ifdef COUNTER4_READOUT_THRESH_CMP_EN
    chk({tag, ".thresh"},    bus.thresh_Pad,    e_thr);
`endif
  endtask

  task automatic step(input string tag, input logic [3:0] c, input logic cap);
    {bus.count3_Pad, bus.count2_Pad, bus.count1_Pad, bus.count0_Pad} = c;
    bus.cap_Pad = cap;
    e_wrap = (mprev == 4'd15) && (c == 4'd0);
    e_thr  = (c == THR[3:0]) && (mprev != THR[3:0]);
    e_drop = 1'b0;
    mprev  = c;
    if (q.size() > 0) begin
      pos++;
      if (pos == 4) begin
        void'(q.pop_front());
        pos = 0;
      end
    end
    if (cap) begin
      if (q.size() < 2) q.push_back(c);
      else              e_drop = 1'b1;
    end
    @(posedge GCLK_Pad);
    #1;
    check_outs(tag);
  endtask

  initial begin
    bus.cap_Pad = 1'b0;
    {bus.count3_Pad, bus.count2_Pad, bus.count1_Pad, bus.count0_Pad} = 4'h0;
    model_reset();
    @(posedge GCLK_Pad);
    #1;
    check_outs("reset");
    rst_Pad = 1'b1;

    // Single capture of 4'b1011
    step("single", 4'd11, 1'b1);
    repeat (5) step("single", 4'd11, 1'b0);

    // Back-to-back: 5 then 6 two cycles later, no gap
    step("b2b", 4'd5, 1'b1);
    step("b2b", 4'd6, 1'b0);
    step("b2b", 4'd6, 1'b1);
    repeat (8) step("b2b", 4'd0, 1'b0);

    // Overflow: third request within one word is dropped
    step("ovf", 4'd3, 1'b1);
    step("ovf", 4'd4, 1'b1);
    step("ovf", 4'd7, 1'b1);
    repeat (9) step("ovf", 4'd1, 1'b0);

    // Wrap detection
    step("wrap", 4'd14, 1'b0);
    step("wrap", 4'd15, 1'b0);
    step("wrap", 4'd0,  1'b0);
    step("wrap", 4'd1,  1'b0);
    step("nowrap", 4'd15, 1'b0);
    step("nowrap", 4'd7,  1'b0);

    // Threshold rising match
    step("thr", 4'd8,  1'b0);
    step("thr", 4'd9,  1'b0);
    step("thr", 4'd9,  1'b0);
    step("thr", 4'd10, 1'b0);

    // Final-bit edge with pending full plus a new request
    step("edge", 4'd2, 1'b1);
    step("edge", 4'd9, 1'b1);
    step("edge", 4'd0, 1'b0);
    step("edge", 4'd0, 1'b0);
    step("edge", 4'd12, 1'b1);
    repeat (9) step("edge", 4'd0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step("rand", 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));

    // Asynchronous reset mid-shift with pending full
    step("rstmid", 4'd2, 1'b1);
    step("rstmid", 4'd3, 1'b1);
    #2;
    rst_Pad = 1'b0;
    #1;
    model_reset();
    check_outs("rst_async");
    @(posedge GCLK_Pad);
    #1;
    check_outs("rst_hold");
    rst_Pad = 1'b1;
    repeat (6) step("post_rst", 4'd5, 1'b0);
    step("post_rst_cap", 4'd10, 1'b1);
    repeat (5) step("post_rst_cap", 4'd10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter4_readout.md
Name: counter4_readout

Overview:
- Downstream consumer of the 4-bit routed counter.
- Samples count0_Pad..count3_Pad every GCLK_Pad cycle and detects wrap-around (15 -> 0).
- On a capture request, snapshots the count and shifts it out serially on a single output pad, with a valid flag.
- Reduces pad count for chip readout. Includes a one-deep pending buffer so back-to-back captures are not lost.

Parameters:
- CNT_W, 4, count width; fixed at 4 for this stage, checked at elaboration.
- MSB_FIRST, 0, serial bit order: 0 = LSB (count0) first, 1 = MSB (count3) first.
- THRESH, 4'd15, match value for the optional threshold detector.

Ports:
- GCLK_Pad  input  1  global clock; all state updates on the rising edge.
- rst_Pad  input  1  reset, asynchronous, active-low.
- count0_Pad  input  1  counter bit 0 (LSB).
- count1_Pad  input  1  counter bit 1.
- count2_Pad  input  1  counter bit 2.
- count3_Pad  input  1  counter bit 3 (MSB).
- cap_Pad  input  1  capture request, sampled at the rising edge.
- ser_Pad  output  1  serial data bit.
- ser_valid_Pad  output  1  ser_Pad holds a valid bit.
- busy_Pad  output  1  shifting, or a capture is pending.
- wrap_Pad  output  1  one-cycle pulse on a 15 -> 0 transition.
- drop_Pad  output  1  one-cycle pulse when a capture request is discarded.

Behaviour:
- Reset: rst_Pad low asynchronously clears all registers:
  - prev count = 0, shift reg = 0, pending = empty, FSM = IDLE, bit index = 0.
  - All outputs = 0.
  - Reset mid-shift aborts the transfer immediately; any pending capture is discarded.
- Count sampling: cur = {count3..count0} is registered into prev every cycle.
- wrap_Pad: registered; 1 for exactly one cycle after an edge where prev == 15 and cur == 0. Any cause of the transition counts, including a counter reset at 15.
  - First cycle after reset: prev = 0, so no wrap is possible.
- FSM states: IDLE and SHIFT.
  - IDLE, cap_Pad = 1 at edge N:
    - Load shift reg with cur as sampled at edge N.
    - Go to SHIFT; drive bit 0 of the order.
    - After edge N: ser_valid_Pad = 1, busy_Pad = 1.
    - Bits are presented after edges N, N+1, N+2, N+3 (order per MSB_FIRST).
  - SHIFT, bit index 3 completes at edge N+4:
    - Pending empty: return to IDLE; ser_valid_Pad = 0, ser_Pad = 0, busy_Pad = 0 after edge N+4.
    - Pending full: load pending into shift reg at edge N+4, clear pending, restart at bit 0. No gap cycle; ser_valid_Pad stays 1.
  - SHIFT, cap_Pad = 1 and pending empty: store cur into pending. Stored value = count at the request edge.
  - SHIFT, cap_Pad = 1 and pending full: request dropped; drop_Pad = 1 for one cycle; pending value unchanged.
  - SHIFT, cap_Pad = 1 on the same edge the final bit completes: treated as an IDLE capture of cur at that edge (pending assumed empty). If pending is full, the pending value shifts next and the new request goes into pending.
- Latency: capture edge to first valid bit is 0 cycles (registered output updates on the capture edge). One 4-bit word occupies 4 cycles; sustained throughput is one word per 4 cycles.
- ser_Pad = 0 whenever ser_valid_Pad = 0.

Optional Feature:
- Macro: COUNTER4_READOUT_THRESH_CMP_EN.
- Defined:
  - Adds output port thresh_Pad (1 bit).
  - Registered one-cycle pulse when cur == THRESH and prev != THRESH (rising match only). A count held at THRESH does not re-pulse.
  - Reset value 0.
- Undefined: no thresh_Pad port and no compare logic; THRESH is ignored.

Test Plan:
- Reset: assert rst_Pad = 0 mid-SHIFT with pending full -> all outputs 0 immediately (asynchronous); after release, no serial output until a new cap_Pad.
- Single capture: count = 4'b1011, MSB_FIRST = 0, cap_Pad high for one edge -> ser_Pad = 1,1,0,1 over 4 cycles with ser_valid_Pad = 1; then ser_valid_Pad = 0, busy_Pad = 0.
- Back-to-back: capture count 5, then cap_Pad again 2 cycles later with count 6 -> 8 consecutive valid cycles: 1,0,1,0 then 0,1,1,0; no gap; drop_Pad stays 0.
- Overflow: three cap_Pad pulses within one 4-cycle shift -> third request dropped, drop_Pad = 1 for exactly one cycle; only two words emitted.
- Wrap: drive count 14, 15, 0, 1 -> wrap_Pad = 1 for exactly one cycle, after the 15 -> 0 edge. Drive 15 -> 7 -> no pulse.
- With COUNTER4_READOUT_THRESH_CMP_EN, THRESH = 9: count 8, 9, 9, 10 -> thresh_Pad pulses once, after the 8 -> 9 edge.
